// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
// - ALU control codes: the encoding the decode-side ALU control block drives.
// - FSM state type for alu_exec.
// - Default widths for RV64.
package alu_pkg;

  localparam int XLEN_DEF = 64;
  localparam int SHW_DEF  = 6;
  localparam int TAGW_DEF = 5;

  typedef enum logic [2:0] {
    ALU_ADD     = 3'b000,
    ALU_SUB     = 3'b001,
    ALU_SLL     = 3'b010,
    ALU_SRL     = 3'b011,
    ALU_SRA     = 3'b100,
    ALU_OR      = 3'b101,
    ALU_AND     = 3'b110,
    ALU_ILLEGAL = 3'b111   // decoder default
  } alu_ctl_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift(input alu_ctl_t c);
    return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// alu_serial_shifter: result register plus a down counter that shifts the
// register by one bit position per cycle while the count is non-zero.
// The register doubles as the ALU result register: single-cycle results are
// loaded with a count of zero and simply held.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_load         : load i_load_data / i_load_cnt / i_mode this cycle
//   i_load_data    : value to load (ALU result or shift operand)
//   i_load_cnt     : number of single-bit shifts still to do
//   i_mode         : ALU control code selecting SLL/SRL/SRA
//   o_data         : register contents
//   o_busy         : count non-zero (shifting)
//   o_last         : count is 1, so this cycle performs the final shift
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int SHW  = SHW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_load_data,
  input  logic [SHW-1:0]  i_load_cnt,
  input  logic [2:0]      i_mode,
  output logic [XLEN-1:0] o_data,
  output logic            o_busy,
  output logic            o_last
);

  logic [XLEN-1:0] r_data;
  logic [SHW-1:0]  r_cnt;
  alu_ctl_t        r_mode;

  function automatic logic [XLEN-1:0] shift_one(input logic [XLEN-1:0] d,
                                                input alu_ctl_t        m);
    logic signed [XLEN-1:0] d_s;
    d_s = d;
    case (m)
      ALU_SLL: return {d[XLEN-2:0], 1'b0};
      ALU_SRL: return {1'b0, d[XLEN-1:1]};
      ALU_SRA: return $unsigned(d_s >>> 1);
      default: return d;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_mode <= ALU_ADD;
    end else if (i_load) begin
      r_data <= i_load_data;
      r_cnt  <= i_load_cnt;
      r_mode <= alu_ctl_t'(i_mode);
    end else if (r_cnt != '0) begin
      r_data <= shift_one(r_data, r_mode);
      r_cnt  <= r_cnt - SHW'(1);
    end
  end

  assign o_data = r_data;
  assign o_busy = (r_cnt != '0);
  assign o_last = (r_cnt == SHW'(1));

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with valid/ready handshake on both sides.
// ADD/SUB/OR/AND/ILLEGAL and zero-amount shifts complete in one cycle;
// non-zero shifts run through the serial shifter, one bit per cycle.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operation handshake (ready only in IDLE)
//   alu_ctl, op_a, op_b   : control code and operands (shamt = op_b[SHW-1:0])
//   rd_in                 : destination tag, echoed on rd_out
//   out_valid / out_ready : result handshake
//   result, rd_out, err   : registered result, tag, illegal-code flag
module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int SHW  = SHW_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_ctl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [TAGW-1:0] rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] rd_out,
  output logic            err
);

  alu_state_t      r_state;
  alu_state_t      w_state_nxt;
  logic [TAGW-1:0] r_rd;
  logic            r_err;

  alu_ctl_t        w_ctl;
  logic            w_accept;
  logic [SHW-1:0]  w_shamt;
  logic            w_multi;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_sh_data;
  logic            w_sh_busy;
  logic            w_sh_last;

  assign w_ctl    = alu_ctl_t'(alu_ctl);
  // Ready is forced low while reset is held, not just by the IDLE state.
  assign in_ready = rst_n && (r_state == ST_IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_shamt  = op_b[SHW-1:0];
  assign w_multi  = is_shift(w_ctl) && (w_shamt != '0);

  // Accept-cycle value: final result for single-cycle ops, starting operand
  // for shifts.
  always_comb begin
    w_alu = '0;
    case (w_ctl)
      ALU_ADD: w_alu = op_a + op_b;
      ALU_SUB: w_alu = op_a + ~op_b + XLEN'(1);
      ALU_SLL,
      ALU_SRL,
      ALU_SRA: w_alu = op_a;
      ALU_OR:  w_alu = op_a | op_b;
      ALU_AND: w_alu = op_a & op_b;
      default: w_alu = '0;
    endcase
  end

  alu_serial_shifter #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_accept),
    .i_load_data (w_alu),
    .i_load_cnt  (w_multi ? w_shamt : '0),
    .i_mode      (alu_ctl),
    .o_data      (w_sh_data),
    .o_busy      (w_sh_busy),
    .o_last      (w_sh_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = w_multi ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (w_sh_last || !w_sh_busy) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rd    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rd  <= rd_in;
        r_err <= (w_ctl == ALU_ILLEGAL);
      end else if (r_state == ST_DONE && out_ready) begin
        r_err <= 1'b0;
      end
    end
  end

  assign out_valid = (r_state == ST_DONE);
  assign result    = w_sh_data;
  assign rd_out    = r_rd;
  assign err       = r_err;

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute-stage ALU that consumes the 3-bit ALU control code and produces a registered result over a valid/ready handshake.
- Add, sub and logic ops finish in one cycle. Shifts use a serial shifter, one bit position per cycle, to save area.
- Sits between decode (which supplies ALU_Ctl, operands and rd tag) and writeback.

Parameters:
- XLEN, 64, operand/result width (RV64).
- SHW, 6, shift-amount width; must equal log2(XLEN).
- TAGW, 5, destination-register tag width.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept an operation.
- alu_ctl  input  3  ALU control code.
- op_a  input  XLEN  operand A.
- op_b  input  XLEN  operand B; shifts use op_b[SHW-1:0].
- rd_in  input  TAGW  destination tag.
- out_valid  output  1  result available.
- out_ready  input  1  writeback accepts result.
- result  output  XLEN  registered result.
- rd_out  output  TAGW  tag associated with result.
- err  output  1  illegal control code; qualified by out_valid.

Behaviour:
- Encoding of alu_ctl:
  - 000 ADD, 001 SUB, 010 SLL, 011 SRL, 100 SRA, 101 OR, 110 AND.
  - 111 ILLEGAL, which is the decoder's default.
- Reset (async, rst_n low): state=IDLE, in_ready=0 while rst_n low, out_valid=0, result=0, rd_out=0, err=0, internal shift count=0.
- in_ready=1 only when state==IDLE. An operation is accepted when in_valid && in_ready.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, on accept:
  - ADD/SUB/OR/AND: compute in the accept cycle; result registered; go to DONE. out_valid is high the cycle after accept (latency 1).
  - ILLEGAL: result=0, err=1, go to DONE (latency 1).
  - SLL/SRL/SRA with shamt=0: result=op_a, go to DONE (latency 1).
  - SLL/SRL/SRA with shamt>0: load op_a into the result register and the count with shamt; go to SHIFT.
- SHIFT, each cycle:
  - Shift the result register by 1: SLL left with zero fill; SRL right with zero fill; SRA right replicating bit XLEN-1.
  - Decrement the count. When the count reaches 0 this cycle, go to DONE.
  - Total latency from accept to out_valid = shamt+1 cycles; maximum 64.
- DONE:
  - out_valid=1; result/rd_out/err are stable until handshake.
  - If out_ready=1, return to IDLE next cycle with out_valid=0 and err cleared.
  - Back-to-back issue is not supported: the earliest next accept is the cycle after the DONE handshake, so throughput is at most 1 op per 2 cycles.
- Arithmetic is modulo 2^XLEN with no overflow flag. SUB computes op_a + ~op_b + 1.
- Inputs are don't-care when they are not being accepted. alu_ctl/op_b are sampled only at accept, so changing them mid-shift has no effect.
- out_ready held low in DONE: the unit stalls indefinitely with outputs held.
- rst_n asserted mid-SHIFT or in DONE: the operation is abandoned immediately, all outputs take reset values, and no result is delivered after release.
- The first accept is possible in the first clk edge after rst_n deasserts.

Decomposition:
- Shared package (alu_pkg):
  - ALU_Ctl code constants: ADD, SUB, SLL, SRL, SRA, OR, AND, ILLEGAL.
  - Typedef for the 3-bit control.
  - XLEN default.
  - The same constants are to be used by the decode-side ALU control block.
- Sub-module: alu_serial_shifter (shift register + down counter + busy/last flag). The FSM and combinational ops stay in alu_exec.

Test Plan:
- ADD: alu_ctl=000, op_a=5, op_b=7, out_ready=1 → out_valid 1 cycle after accept, result=12, err=0, rd_out echoes rd_in=3.
- SUB wrap: op_a=0, op_b=1 → result=0xFFFF_FFFF_FFFF_FFFF, latency 1.
- SRA: op_a=0x8000_0000_0000_0000, shamt=4 → in_ready low for 4 SHIFT cycles, out_valid at accept+5, result=0xF800_0000_0000_0000. With SRL the same stimulus gives 0x0800_0000_0000_0000.
- Shift edge cases: SLL shamt=0, op_a=0xA5 → result=0xA5 at latency 1. SLL shamt=63, op_a=1 → result=0x8000_0000_0000_0000 at latency 64.
- Illegal and backpressure: alu_ctl=111 with out_ready=0 for 10 cycles → out_valid held, err=1, result=0, in_ready=0 throughout. Then out_ready=1 → IDLE next cycle, err=0.
- Reset mid-shift: rst_n low during an SLL with shamt=20 at cycle 5 → out_valid=0 and result=0 immediately. After release, no stale out_valid, and in_ready=1 on the first edge.
